// File: rtl/inv_round_tf.sv
// Iterative AES inverse round transform. The block applies InvShiftRows, InvSubBytes,
// AddRoundKey and then InvMixColumns, which is skipped on the final round.
// InvSubBytes handles one 32-bit column per cycle, so only four inverse S-boxes exist.
//
//   state | meaning
//   ------+------------------------------------------------------------------
//   IDLE  | waiting for start_i; s_o/s_isr_o hold the last results
//   SUB   | inverse S-box on column col of st, one column per cycle
//   MIX   | add round key, optional InvMixColumns, publish s_o, pulse done_o
module inv_round_tf (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_i,
    input  logic [127:0] s_i,
    input  logic [127:0] rk_i,
    input  logic         last_i,
    output logic [127:0] s_isr_o,
    output logic [127:0] s_o,
    output logic         busy_o,
    output logic         done_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        MIX  = 2'd2
    } state_t;

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX[b];
    endfunction

    // Byte i sits at [127-8i -: 8] and has row i%4 and column i/4.
    // Row r rotates right by r columns.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] x);
        logic [127:0] y;
        y = '0;
        for (int i = 0; i < 16; i++) begin
            y[127-8*i -: 8] = x[127-8*((i % 4) + 4*(((i / 4) - (i % 4)) & 3)) -: 8];
        end
        return y;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiplies by a constant of at most 0x0f, which covers the coefficients 09/0b/0d/0e.
    function automatic logic [7:0] gf_mul(input logic [7:0] b, input logic [3:0] k);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return (k[3] ? x8 : 8'h00) ^ (k[2] ? x4 : 8'h00) ^
               (k[1] ? x2 : 8'h00) ^ (k[0] ? b  : 8'h00);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] w);
        logic [7:0] a0, a1, a2, a3;
        a0 = w[31:24];
        a1 = w[23:16];
        a2 = w[15:8];
        a3 = w[7:0];
        return {gf_mul(a0, 4'he) ^ gf_mul(a1, 4'hb) ^ gf_mul(a2, 4'hd) ^ gf_mul(a3, 4'h9),
                gf_mul(a0, 4'h9) ^ gf_mul(a1, 4'he) ^ gf_mul(a2, 4'hb) ^ gf_mul(a3, 4'hd),
                gf_mul(a0, 4'hd) ^ gf_mul(a1, 4'h9) ^ gf_mul(a2, 4'he) ^ gf_mul(a3, 4'hb),
                gf_mul(a0, 4'hb) ^ gf_mul(a1, 4'hd) ^ gf_mul(a2, 4'h9) ^ gf_mul(a3, 4'he)};
    endfunction

    state_t       state;
    logic [1:0]   col;
    logic [127:0] st;
    logic [127:0] rk;
    logic         last;

    logic [31:0]  col_word;
    logic [31:0]  sub_word;
    logic [127:0] key_added;
    logic [127:0] mixed;

    // Pick the active column and pass it through the four shared inverse S-boxes.
    always_comb begin
        col_word = st[127:96];
        case (col)
            2'd0: col_word = st[127:96];
            2'd1: col_word = st[95:64];
            2'd2: col_word = st[63:32];
            2'd3: col_word = st[31:0];
            default: col_word = st[127:96];
        endcase
        sub_word = {inv_sbox(col_word[31:24]), inv_sbox(col_word[23:16]),
                    inv_sbox(col_word[15:8]),  inv_sbox(col_word[7:0])};
    end

    // Round key addition followed by InvMixColumns on all four columns.
    always_comb begin
        key_added = st ^ rk;
        mixed     = {inv_mix_col(key_added[127:96]), inv_mix_col(key_added[95:64]),
                     inv_mix_col(key_added[63:32]),  inv_mix_col(key_added[31:0])};
    end

    // Round sequencer: accept a request, substitute one column per cycle, then mix and publish.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            col     <= 2'd0;
            st      <= '0;
            rk      <= '0;
            last    <= 1'b0;
            s_o     <= '0;
            s_isr_o <= '0;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        st      <= inv_shift_rows(s_i);
                        s_isr_o <= inv_shift_rows(s_i);
                        rk      <= rk_i;
                        last    <= last_i;
                        col     <= 2'd0;
                        busy_o  <= 1'b1;
                        state   <= SUB;
                    end
                end
                SUB: begin
                    case (col)
                        2'd0: st[127:96] <= sub_word;
                        2'd1: st[95:64]  <= sub_word;
                        2'd2: st[63:32]  <= sub_word;
                        2'd3: st[31:0]   <= sub_word;
                        default: st[127:96] <= sub_word;
                    endcase
                    col <= col + 2'd1;
                    if (col == 2'd3) begin
                        state <= MIX;
                    end
                end
                MIX: begin
                    s_o    <= last ? key_added : mixed;
                    done_o <= 1'b1;
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inv_round_tf.sv
// Directed bench for inv_round_tf: reset, S-box/key/row checks, FIPS-197 C.1 decryption, handshake.
module tb_inv_round_tf;

    logic         clk;
    logic         rst;
    logic         start_i;
    logic [127:0] s_i;
    logic [127:0] rk_i;
    logic         last_i;
    logic [127:0] s_isr_o;
    logic [127:0] s_o;
    logic         busy_o;
    logic         done_o;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] ROW_IN   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] ROW_ISR  = 128'h000d0a0704010e0b0805020f0c090603;
    localparam logic [127:0] ROW_OUT  = 128'h52f3a3383009d79ebf366afb8140a5d5;
    localparam logic [127:0] KEY_PAT  = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] ALL_63   = {16{8'h63}};
    localparam logic [127:0] ALL_52   = {16{8'h52}};

    logic [127:0] round_key [10] = '{
        128'h549932d1f08557681093ed9cbe2c974e,
        128'h47438735a41c65b9e016baf4aebf7ad2,
        128'h14f9701ae35fe28c440adf4d4ea9c026,
        128'h5e390f7df7a69296a7553dc10aa31f6b,
        128'h3caaa3e8a99f9deb50f3af57adf622aa,
        128'h47f7f7bc95353e03f96c32bcfd058dfd,
        128'hb6ff744ed2c2c9bf6c590cbf0469bf41,
        128'hb692cf0b643dbdf1be9bc5006830b3fe,
        128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
        128'h000102030405060708090a0b0c0d0e0f
    };

    logic [127:0] round_out [10] = '{
        128'h54d990a16ba09ab596bbf40ea111702f,
        128'h3e1c22c0b6fcbf768da85067f6170495,
        128'hb458124c68b68a014b99f82e5f15554c,
        128'he8dab6901477d4653ff7f5e2e747dd4f,
        128'h36339d50f9b539269f2c092dc4406d23,
        128'h2d6d7ef03f33e334093602dd5bfb12c7,
        128'h3bd92268fc74fb735767cbe0c0590e2d,
        128'ha7be1a6997ad739bd8c9ca451f618b61,
        128'h6353e08c0960e104cd70b751bacad0e7,
        128'h00112233445566778899aabbccddeeff
    };

    inv_round_tf dut (
        .clk     (clk),
        .rst     (rst),
        .start_i (start_i),
        .s_i     (s_i),
        .rk_i    (rk_i),
        .last_i  (last_i),
        .s_isr_o (s_isr_o),
        .s_o     (s_o),
        .busy_o  (busy_o),
        .done_o  (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one request from #1 after an edge and wait (bounded) for done_o.
    // lat is the cycle of done_o counted from acceptance (0 on timeout).
    task automatic do_op(input logic [127:0] s, input logic [127:0] k, input logic l,
                         output int lat, output logic [7:0] busy_seen,
                         output logic [127:0] isr_t1);
        s_i = s;
        rk_i = k;
        last_i = l;
        start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        lat = 0;
        busy_seen = 8'h00;
        isr_t1 = s_isr_o;
        for (int n = 1; n <= 20; n++) begin
            if (n < 8) busy_seen[n] = busy_o;
            if (done_o) begin
                lat = n;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++; if (s_o !== 128'h0)     begin errors++; $display("FAIL reset_s_o got %h want 0", s_o); end
        checks++; if (s_isr_o !== 128'h0) begin errors++; $display("FAIL reset_s_isr got %h want 0", s_isr_o); end
        checks++; if (done_o !== 1'b0)    begin errors++; $display("FAIL reset_done got %b want 0", done_o); end
        checks++; if (busy_o !== 1'b0)    begin errors++; $display("FAIL reset_busy got %b want 0", busy_o); end
    endtask

    task automatic test_sbox_passthrough();
        int lat;
        logic [7:0] bs;
        logic [127:0] isr;
        do_op(ALL_63, 128'h0, 1'b1, lat, bs, isr);
        checks++; if (lat !== 6)          begin errors++; $display("FAIL sbox_latency got %0d want 6", lat); end
        checks++; if (bs !== 8'h3e)       begin errors++; $display("FAIL sbox_busy_profile got %h want 3e", bs); end
        checks++; if (s_o !== 128'h0)     begin errors++; $display("FAIL sbox_63_to_00 got %h want 0", s_o); end
        do_op(128'h0, 128'h0, 1'b0, lat, bs, isr);
        checks++; if (lat !== 6)          begin errors++; $display("FAIL mix_latency got %0d want 6", lat); end
        checks++; if (s_o !== ALL_52)     begin errors++; $display("FAIL mix_uniform got %h want %h", s_o, ALL_52); end
    endtask

    task automatic test_key_add();
        int lat;
        logic [7:0] bs;
        logic [127:0] isr;
        do_op(ALL_63, KEY_PAT, 1'b1, lat, bs, isr);
        checks++; if (lat !== 6)          begin errors++; $display("FAIL keyadd_latency got %0d want 6", lat); end
        checks++; if (s_o !== KEY_PAT)    begin errors++; $display("FAIL keyadd got %h want %h", s_o, KEY_PAT); end
    endtask

    task automatic test_row_perm();
        int lat;
        logic [7:0] bs;
        logic [127:0] isr;
        do_op(ROW_IN, 128'h0, 1'b1, lat, bs, isr);
        checks++; if (isr !== ROW_ISR)    begin errors++; $display("FAIL row_isr_t1 got %h want %h", isr, ROW_ISR); end
        checks++; if (s_o !== ROW_OUT)    begin errors++; $display("FAIL row_sbox got %h want %h", s_o, ROW_OUT); end
        checks++; if (s_isr_o !== ROW_ISR) begin errors++; $display("FAIL row_isr_held got %h want %h", s_isr_o, ROW_ISR); end
    endtask

    task automatic test_reset_midop();
        int ndone;
        s_i = ALL_63;
        rk_i = KEY_PAT;
        last_i = 1'b0;
        start_i = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (s_o !== 128'h0)     begin errors++; $display("FAIL midrst_s_o got %h want 0", s_o); end
        checks++; if (s_isr_o !== 128'h0) begin errors++; $display("FAIL midrst_s_isr got %h want 0", s_isr_o); end
        checks++; if (done_o !== 1'b0)    begin errors++; $display("FAIL midrst_done got %b want 0", done_o); end
        checks++; if (busy_o !== 1'b0)    begin errors++; $display("FAIL midrst_busy got %b want 0", busy_o); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        start_i = 1'b0;
        ndone = 0;
        for (int n = 0; n < 20; n++) begin
            if (done_o) ndone++;
            @(posedge clk);
            #1;
        end
        checks++; if (ndone !== 0)        begin errors++; $display("FAIL midrst_no_done got %0d want 0", ndone); end
    endtask

    task automatic test_fips_rounds();
        int lat;
        logic [7:0] bs;
        logic [127:0] isr;
        logic [127:0] st;
        st = 128'h69c4e0d86a7b0430d8cdb78070b4c55a ^ 128'h13111d7fe3944a17f307a78b4d2b30c5;
        for (int r = 0; r < 10; r++) begin
            do_op(st, round_key[r], (r == 9), lat, bs, isr);
            checks++; if (lat !== 6) begin errors++; $display("FAIL fips_latency round %0d got %0d want 6", r + 1, lat); end
            checks++; if (s_o !== round_out[r]) begin errors++; $display("FAIL fips_round %0d got %h want %h", r + 1, s_o, round_out[r]); end
            st = s_o;
        end
    endtask

    task automatic test_ignored_start();
        int ndone;
        int first;
        s_i = ROW_IN;
        rk_i = 128'h0;
        last_i = 1'b1;
        start_i = 1'b1;
        @(posedge clk);
        #1;
        ndone = 0;
        first = 0;
        for (int n = 1; n <= 20; n++) begin
            if (n == 2) begin
                start_i = 1'b1;
                s_i = ALL_63;
                rk_i = KEY_PAT;
            end else begin
                start_i = 1'b0;
            end
            if (done_o) begin
                ndone++;
                if (first == 0) first = n;
            end
            @(posedge clk);
            #1;
        end
        start_i = 1'b0;
        checks++; if (ndone !== 1)        begin errors++; $display("FAIL ignored_done_count got %0d want 1", ndone); end
        checks++; if (first !== 6)        begin errors++; $display("FAIL ignored_done_cycle got %0d want 6", first); end
        checks++; if (s_o !== ROW_OUT)    begin errors++; $display("FAIL ignored_result got %h want %h", s_o, ROW_OUT); end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [7:0] bs;
        logic [127:0] isr;
        do_op(ALL_63, KEY_PAT, 1'b1, lat, bs, isr);
        checks++; if (lat !== 6)          begin errors++; $display("FAIL b2b_first_latency got %0d want 6", lat); end
        checks++; if (s_o !== KEY_PAT)    begin errors++; $display("FAIL b2b_first got %h want %h", s_o, KEY_PAT); end
        do_op(128'h0, 128'h0, 1'b0, lat, bs, isr);
        checks++; if (lat !== 6)          begin errors++; $display("FAIL b2b_second_latency got %0d want 6", lat); end
        checks++; if (s_o !== ALL_52)     begin errors++; $display("FAIL b2b_second got %h want %h", s_o, ALL_52); end
    endtask

    task automatic test_continuous();
        int nd;
        int dc [8];
        for (int i = 0; i < 8; i++) dc[i] = 0;
        nd = 0;
        s_i = ROW_IN;
        rk_i = 128'h0;
        last_i = 1'b1;
        start_i = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (done_o) begin
                if (nd < 8) dc[nd] = n;
                nd++;
            end
        end
        start_i = 1'b0;
        checks++; if (nd !== 6)           begin errors++; $display("FAIL cont_done_count got %0d want 6", nd); end
        for (int i = 0; i < 6; i++) begin
            checks++; if (dc[i] !== 6 * (i + 1)) begin errors++; $display("FAIL cont_done_cycle %0d got %0d want %0d", i, dc[i], 6 * (i + 1)); end
        end
        checks++; if (s_o !== ROW_OUT)    begin errors++; $display("FAIL cont_result got %h want %h", s_o, ROW_OUT); end
        repeat (8) @(posedge clk);
        #1;
        checks++; if (busy_o !== 1'b0)    begin errors++; $display("FAIL cont_drain_busy got %b want 0", busy_o); end
    endtask

    initial begin
        rst = 1'b1;
        start_i = 1'b0;
        s_i = '0;
        rk_i = '0;
        last_i = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_sbox_passthrough();
        test_key_add();
        test_row_perm();
        test_reset_midop();
        test_fips_rounds();
        test_ignored_start();
        test_back_to_back();
        test_continuous();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
